vc_writeback_buffer: RTL and testbench

// Buffers dirty lines evicted by the victim cache (its wb_address/wb_data) and drains them to physical memory.

---
 rtl/vc_writeback_buffer_if.sv | 32 +++
 rtl/vc_writeback_buffer.sv | 138 +++++++++++++
 tb/tb_vc_writeback_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vc_writeback_buffer_if.sv
// Bundles the enqueue, L2 line-fill read, physical-memory and status signals
// of the victim-cache writeback buffer.
interface vc_writeback_buffer_if;
  logic         enq_valid;
  logic [11:0]  enq_address;
  logic [127:0] enq_data;
  logic         enq_ready;

  logic         rd_req;
  logic [11:0]  rd_address;
  logic         rd_resp;
  logic [127:0] rd_data;

  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  logic         empty;

  modport master (
    output enq_valid, enq_address, enq_data, rd_req, rd_address, pmem_rdata, pmem_resp,
    input  enq_ready, rd_resp, rd_data, pmem_read, pmem_write, pmem_address, pmem_wdata, empty
  );

  modport slave (
    input  enq_valid, enq_address, enq_data, rd_req, rd_address, pmem_rdata, pmem_resp,
    output enq_ready, rd_resp, rd_data, pmem_read, pmem_write, pmem_address, pmem_wdata, empty
  );
endinterface

// File: rtl/vc_writeback_buffer.sv
// Writeback buffer between the victim cache and physical memory: coalesces evicted
// dirty lines, drains them FIFO-order, and serves L2 line fills with snoop forwarding.
module vc_writeback_buffer #(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  vc_writeback_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, HIT, READ, WRITE} state_t;

  state_t             state_q, state_d;
  logic               valid_q [DEPTH];
  logic [11:0]        addr_q  [DEPTH];
  logic [127:0]       data_q  [DEPTH];
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic [127:0]       rdData_q, rdData_d;

  logic               coalHit;
  logic [PTR_W-1:0]   coalIdx;
  logic               snoopHit;
  logic [127:0]       snoopData;
  logic [PTR_W-1:0]   scanIdx;
  logic               full, push, pop;

  assign full          = (count_q == FULL_CNT);
  assign pop           = (state_q == WRITE) && bus.pmem_resp;
  assign push          = bus.enq_valid && !coalHit && !full;
  assign bus.enq_ready = !full || coalHit;
  assign bus.empty     = (count_q == '0);

  // The head being written is excluded from coalescing so its in-flight data stays stable;
  // the snoop walks oldest to youngest so the last match is the freshest copy.
  always_comb begin
    coalHit   = 1'b0;
    coalIdx   = '0;
    snoopHit  = 1'b0;
    snoopData = '0;
    scanIdx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.enq_address) &&
          !((state_q == WRITE) && (PTR_W'(i) == head_q))) begin
        coalHit = 1'b1;
        coalIdx = PTR_W'(i);
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head_q + PTR_W'(k);
      if (valid_q[scanIdx] && (addr_q[scanIdx] == bus.rd_address)) begin
        snoopHit  = 1'b1;
        snoopData = data_q[scanIdx];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    rdData_d         = rdData_q;
    bus.rd_resp      = 1'b0;
    bus.rd_data      = rdData_q;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (full) begin
          state_d = WRITE;
        end else if (bus.rd_req && snoopHit) begin
          state_d  = HIT;
          rdData_d = snoopData;
        end else if (bus.rd_req) begin
          state_d = READ;
        end else if (count_q != '0) begin
          state_d = WRITE;
        end
      end
      HIT: begin
        bus.rd_resp = 1'b1;
        state_d     = IDLE;
      end
      READ: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.rd_address, 4'b0000};
        bus.rd_data      = bus.pmem_rdata;
        if (bus.pmem_resp) begin
          bus.rd_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {addr_q[head_q], 4'b0000};
        bus.pmem_wdata   = data_q[head_q];
        if (bus.pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rdData_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      rdData_q <= rdData_d;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (bus.enq_valid && coalHit) begin
        data_q[coalIdx] <= bus.enq_data;
      end else if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= bus.enq_address;
        data_q[tail_q]  <= bus.enq_data;
        tail_q          <= tail_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// Directed self-checking bench for vc_writeback_buffer; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_vc_writeback_buffer;

  localparam logic [11:0]  ADDR_A = 12'h010;
  localparam logic [127:0] D0     = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] D1     = 128'hD1D1_0000_D1D1_0000_D1D1_0000_D1D1_0001;
  localparam logic [127:0] DX     = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
  localparam logic [127:0] E0     = 128'hE0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0_E0E0;
  localparam logic [127:0] E1     = 128'hE1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1_E1E1;
  localparam logic [127:0] RDAT   = 128'h5A5A_A5A5_1234_5678_9ABC_DEF0_0F0F_F0F0;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  vc_writeback_buffer_if bus ();

  vc_writeback_buffer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one enqueue for a single cycle and returns on the next falling edge.
  task automatic applyStimulus(input logic [11:0] addr, input logic [127:0] data);
    bus.enq_valid   = 1'b1;
    bus.enq_address = addr;
    bus.enq_data    = data;
    @(negedge clk);
    bus.enq_valid   = 1'b0;
  endtask

  task automatic waitWrite(input string tag);
    for (int i = 0; i < 20 && !bus.pmem_write; i++) @(negedge clk);
    checkOutput({tag, "_write_seen"}, 128'(bus.pmem_write), 128'(1'b1));
  endtask

  task automatic serviceWrite(input string tag, input logic [15:0] expAddr, input logic [127:0] expData);
    waitWrite(tag);
    checkOutput({tag, "_addr"},  128'(bus.pmem_address), 128'(expAddr));
    checkOutput({tag, "_wdata"}, bus.pmem_wdata, expData);
    checkOutput({tag, "_no_rd"}, 128'(bus.pmem_read), 128'(1'b0));
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
  endtask

  initial begin
    assertCount     = 0;
    failCount       = 0;
    rst             = 1'b1;
    bus.enq_valid   = 1'b0;
    bus.enq_address = '0;
    bus.enq_data    = '0;
    bus.rd_req      = 1'b0;
    bus.rd_address  = '0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_rd_resp",   128'(bus.rd_resp),      '0);
    checkOutput("rst_pmem_rd",   128'(bus.pmem_read),    '0);
    checkOutput("rst_pmem_wr",   128'(bus.pmem_write),   '0);
    checkOutput("rst_pmem_addr", 128'(bus.pmem_address), '0);
    checkOutput("rst_wdata",     bus.pmem_wdata,         '0);
    checkOutput("rst_rd_data",   bus.rd_data,            '0);
    checkOutput("rst_enq_ready", 128'(bus.enq_ready),    128'(1'b1));
    checkOutput("rst_empty",     128'(bus.empty),        128'(1'b1));

    // Single enqueue drained to memory
    applyStimulus(ADDR_A, D0);
    checkOutput("t1_not_empty", 128'(bus.empty), '0);
    serviceWrite("t1", 16'h0100, D0);
    checkOutput("t1_empty", 128'(bus.empty), 128'(1'b1));

    // Fill, reject a fifth distinct line, coalesce into the second entry while full
    applyStimulus(12'h100, 128'h100);
    applyStimulus(12'h101, 128'h101);
    applyStimulus(12'h102, 128'h102);
    applyStimulus(12'h103, 128'h103);
    bus.enq_valid   = 1'b1;
    bus.enq_address = 12'h104;
    bus.enq_data    = 128'h104;
    #1 checkOutput("t2_full_ready", 128'(bus.enq_ready), '0);
    @(negedge clk);
    bus.enq_address = 12'h101;
    bus.enq_data    = DX;
    #1 checkOutput("t2_coal_ready", 128'(bus.enq_ready), 128'(1'b1));
    @(negedge clk);
    bus.enq_valid   = 1'b0;
    bus.enq_address = 12'h105;
    #1 checkOutput("t2_still_full", 128'(bus.enq_ready), '0);
    serviceWrite("t2_e0", 16'h1000, 128'h100);
    serviceWrite("t2_e1", 16'h1010, DX);
    serviceWrite("t2_e2", 16'h1020, 128'h102);
    serviceWrite("t2_e3", 16'h1030, 128'h103);
    checkOutput("t2_empty", 128'(bus.empty), 128'(1'b1));

    // Snoop hit forwarded without a memory read
    applyStimulus(ADDR_A, D0);
    bus.rd_req     = 1'b1;
    bus.rd_address = ADDR_A;
    #1 checkOutput("t3_resp_early", 128'(bus.rd_resp), '0);
    @(negedge clk);
    checkOutput("t3_resp",    128'(bus.rd_resp),   128'(1'b1));
    checkOutput("t3_data",    bus.rd_data,         D0);
    checkOutput("t3_no_pmem", 128'(bus.pmem_read), '0);
    bus.rd_req = 1'b0;
    @(negedge clk);
    checkOutput("t3_resp_pulse", 128'(bus.rd_resp),   '0);
    checkOutput("t3_no_pmem2",   128'(bus.pmem_read), '0);
    serviceWrite("t3", 16'h0100, D0);

    // Read miss wins over pending writes, then the writes drain
    applyStimulus(12'h020, E0);
    bus.rd_req     = 1'b1;
    bus.rd_address = 12'h3FF;
    applyStimulus(12'h021, E1);
    checkOutput("t4_pmem_rd",   128'(bus.pmem_read),    128'(1'b1));
    checkOutput("t4_pmem_wr",   128'(bus.pmem_write),   '0);
    checkOutput("t4_pmem_addr", 128'(bus.pmem_address), 128'(16'h3FF0));
    checkOutput("t4_resp_wait", 128'(bus.rd_resp),      '0);
    bus.pmem_rdata = RDAT;
    bus.pmem_resp  = 1'b1;
    #1 checkOutput("t4_resp", 128'(bus.rd_resp), 128'(1'b1));
    checkOutput("t4_data", bus.rd_data, RDAT);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.rd_req    = 1'b0;
    checkOutput("t4_resp_pulse", 128'(bus.rd_resp), '0);
    serviceWrite("t4_e0", 16'h0200, E0);
    serviceWrite("t4_e1", 16'h0210, E1);
    checkOutput("t4_empty", 128'(bus.empty), 128'(1'b1));

    // Same line enqueued while its head copy is in flight goes to a new entry
    applyStimulus(ADDR_A, D0);
    waitWrite("t5_head");
    bus.enq_valid   = 1'b1;
    bus.enq_address = ADDR_A;
    bus.enq_data    = D1;
    #1 checkOutput("t5_ready", 128'(bus.enq_ready), 128'(1'b1));
    @(negedge clk);
    bus.enq_valid = 1'b0;
    checkOutput("t5_head_wdata", bus.pmem_wdata, D0);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    checkOutput("t5_not_empty", 128'(bus.empty), '0);
    bus.rd_req     = 1'b1;
    bus.rd_address = ADDR_A;
    @(negedge clk);
    checkOutput("t5_resp", 128'(bus.rd_resp), 128'(1'b1));
    checkOutput("t5_data", bus.rd_data,       D1);
    bus.rd_req = 1'b0;
    serviceWrite("t5_drain", 16'h0100, D1);
    checkOutput("t5_empty", 128'(bus.empty), 128'(1'b1));

    // Reset in the middle of a write with three entries buffered
    applyStimulus(12'h030, E0);
    applyStimulus(12'h031, E1);
    applyStimulus(12'h032, D0);
    waitWrite("t6_pre");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_pmem_wr",   128'(bus.pmem_write),   '0);
    checkOutput("t6_pmem_rd",   128'(bus.pmem_read),    '0);
    checkOutput("t6_pmem_addr", 128'(bus.pmem_address), '0);
    checkOutput("t6_empty",     128'(bus.empty),        128'(1'b1));
    checkOutput("t6_ready",     128'(bus.enq_ready),    128'(1'b1));
    checkOutput("t6_rd_data",   bus.rd_data,            '0);
    @(negedge clk);
    checkOutput("t6_idle_wr",   128'(bus.pmem_write),   '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
